// File: rtl/execute_mdu.sv
// execute_mdu: multi-cycle RV M-extension unit (shift-add multiply, restoring divide) beside the ALU.
// Optional macro MDU_FAST_MUL_EN: MUL-class ops use a single-cycle full-width product.
module execute_mdu #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            busy_o
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("execute_mdu: XLEN must be 32 or 64");
    end
    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) begin : g_bad_bpc
      $error("execute_mdu: BITS_PER_CYCLE must be 1, 2 or 4");
    end
    if ((XLEN % BITS_PER_CYCLE) != 0) begin : g_bad_div
      $error("execute_mdu: BITS_PER_CYCLE must divide XLEN");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

`ifdef MDU_FAST_MUL_EN
  localparam state_e MUL_ENTRY = S_DONE;
`else
  localparam state_e MUL_ENTRY = S_MUL;
`endif

  state_e              state_r, state_nxt_s;
  logic [CW-1:0]       cnt_r;
  logic [2:0]          op_r;
  logic                neg_q_r, neg_r_r;
  logic [XLEN-1:0]     opnd_r;
  logic [2*XLEN-1:0]   acc_r;
  logic [XLEN-1:0]     result_r;
  logic [4:0]          rd_addr_r;
  logic                res_valid_r, busy_r, idle_r;
  logic                res_valid_nxt_s, busy_nxt_s, idle_nxt_s;

  logic                accept_s, last_s, iterating_s;
  logic                rs1_signed_s, rs2_signed_s, rs1_neg_s, rs2_neg_s;
  logic [XLEN-1:0]     rs1_mag_s, rs2_mag_s;
  logic                div_zero_s, div_ovf_s, special_s;
  logic [XLEN-1:0]     special_res_s;
  logic [XLEN+BITS_PER_CYCLE-1:0] mul_sum_s;
  logic [2*XLEN-1:0]   mul_step_s, div_step_s, step_s;
  logic [XLEN:0]       div_trial_s;
  logic [XLEN-1:0]     div_rem_s, div_quo_s, final_s;

  // Apply the product sign and pick the low or high half.
  function automatic logic [XLEN-1:0] mul_select(input logic [2*XLEN-1:0] prod,
                                                 input logic neg, input logic [1:0] op);
    logic [2*XLEN-1:0] p;
    p = neg ? -prod : prod;
    if (op == 2'd0) begin
      mul_select = p[XLEN-1:0];
    end else begin
      mul_select = p[2*XLEN-1:XLEN];
    end
  endfunction

  // Apply quotient/remainder signs and pick quotient or remainder.
  function automatic logic [XLEN-1:0] div_select(input logic [2*XLEN-1:0] acc,
                                                 input logic neg_q, input logic neg_r,
                                                 input logic sel_rem);
    logic [XLEN-1:0] q, r;
    q = acc[XLEN-1:0];
    r = acc[2*XLEN-1:XLEN];
    if (sel_rem) begin
      div_select = neg_r ? -r : r;
    end else begin
      div_select = neg_q ? -q : q;
    end
  endfunction

  assign req_ready_o = idle_r & ~flush_i & ~rst;
  assign accept_s    = req_valid_i & req_ready_o;
  assign res_valid_o = res_valid_r & ~flush_i;
  assign result_o    = result_r;
  assign rd_addr_o   = rd_addr_r;
  assign busy_o      = busy_r;

  // Operand signedness from funct3.
  always_comb begin
    rs1_signed_s = 1'b0;
    rs2_signed_s = 1'b0;
    case (op_i)
      3'd1, 3'd4, 3'd6: begin
        rs1_signed_s = 1'b1;
        rs2_signed_s = 1'b1;
      end
      3'd2:    rs1_signed_s = 1'b1;
      default: rs1_signed_s = 1'b0;
    endcase
  end

  assign rs1_neg_s = rs1_signed_s & rs1_i[XLEN-1];
  assign rs2_neg_s = rs2_signed_s & rs2_i[XLEN-1];
  assign rs1_mag_s = rs1_neg_s ? -rs1_i : rs1_i;
  assign rs2_mag_s = rs2_neg_s ? -rs2_i : rs2_i;

  assign div_zero_s = (rs2_i == {XLEN{1'b0}});
  assign div_ovf_s  = ~op_i[0] & (rs1_i == MOST_NEG) & (rs2_i == ALL_ONES);
  assign special_s  = op_i[2] & (div_zero_s | div_ovf_s);

  // Architectural results for divide-by-zero and signed overflow.
  always_comb begin
    if (div_zero_s) begin
      special_res_s = op_i[1] ? rs1_i : ALL_ONES;
    end else begin
      special_res_s = op_i[1] ? {XLEN{1'b0}} : rs1_i;
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod_s;
  assign fast_prod_s = {{XLEN{1'b0}}, rs1_mag_s} * {{XLEN{1'b0}}, rs2_mag_s};
`endif

  // Shift-add step: acc holds {partial high, remaining multiplier bits}.
  always_comb begin
    mul_sum_s = {{BITS_PER_CYCLE{1'b0}}, acc_r[2*XLEN-1:XLEN]};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (acc_r[i]) begin
        mul_sum_s = mul_sum_s + ({{BITS_PER_CYCLE{1'b0}}, opnd_r} << i);
      end else begin
        mul_sum_s = mul_sum_s;
      end
    end
    mul_step_s = {mul_sum_s, acc_r[XLEN-1:BITS_PER_CYCLE]};
  end

  // Restoring divide step: acc holds {partial remainder, dividend/quotient}.
  always_comb begin
    div_rem_s   = acc_r[2*XLEN-1:XLEN];
    div_quo_s   = acc_r[XLEN-1:0];
    div_trial_s = {(XLEN+1){1'b0}};
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      div_trial_s = {div_rem_s, div_quo_s[XLEN-1]};
      div_quo_s   = {div_quo_s[XLEN-2:0], 1'b0};
      if (div_trial_s >= {1'b0, opnd_r}) begin
        div_trial_s  = div_trial_s - {1'b0, opnd_r};
        div_quo_s[0] = 1'b1;
      end else begin
        div_quo_s[0] = 1'b0;
      end
      div_rem_s = div_trial_s[XLEN-1:0];
    end
    div_step_s = {div_rem_s, div_quo_s};
  end

  assign step_s      = op_r[2] ? div_step_s : mul_step_s;
  assign last_s      = (cnt_r == CW'(1));
  assign iterating_s = (state_r == S_MUL) || (state_r == S_DIV);
  assign final_s     = op_r[2] ? div_select(step_s, neg_q_r, neg_r_r, op_r[1])
                               : mul_select(step_s, neg_q_r, op_r[1:0]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    if (flush_i) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            if (op_i[2]) begin
              state_nxt_s = special_s ? S_DONE : S_DIV;
            end else begin
              state_nxt_s = MUL_ENTRY;
            end
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_MUL:   state_nxt_s = last_s ? S_DONE : S_MUL;
        S_DIV:   state_nxt_s = last_s ? S_DONE : S_DIV;
        S_DONE:  state_nxt_s = res_ready_i ? S_IDLE : S_DONE;
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the next state so they can be registered.
  always_comb begin
    res_valid_nxt_s = (state_nxt_s == S_DONE);
    busy_nxt_s      = (state_nxt_s != S_IDLE);
    idle_nxt_s      = (state_nxt_s == S_IDLE);
  end

  // Status output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      idle_r      <= 1'b1;
    end else begin
      res_valid_r <= res_valid_nxt_s;
      busy_r      <= busy_nxt_s;
      idle_r      <= idle_nxt_s;
    end
  end

  // Operand latch on accept, iteration, and final result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= {CW{1'b0}};
      op_r      <= 3'd0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      opnd_r    <= {XLEN{1'b0}};
      acc_r     <= {(2*XLEN){1'b0}};
      result_r  <= {XLEN{1'b0}};
      rd_addr_r <= 5'd0;
    end else if (accept_s) begin
      cnt_r     <= CW'(N);
      op_r      <= op_i;
      neg_q_r   <= rs1_neg_s ^ rs2_neg_s;
      neg_r_r   <= rs1_neg_s;
      rd_addr_r <= rd_addr_i;
      if (op_i[2]) begin
        acc_r  <= {{XLEN{1'b0}}, rs1_mag_s};
        opnd_r <= rs2_mag_s;
        if (special_s) begin
          result_r <= special_res_s;
        end
      end else begin
        acc_r  <= {{XLEN{1'b0}}, rs2_mag_s};
        opnd_r <= rs1_mag_s;
`ifdef MDU_FAST_MUL_EN
        result_r <= mul_select(fast_prod_s, rs1_neg_s ^ rs2_neg_s, op_i[1:0]);
`endif
      end
    end else if (iterating_s && !flush_i) begin
      acc_r <= step_s;
      cnt_r <= cnt_r - CW'(1);
      if (last_s) begin
        result_r <= final_s;
      end
    end
  end

endmodule

// File: tb/tb_execute_mdu.sv
// tb_execute_mdu: scoreboard bench for execute_mdu (32-bit/radix-2 and 64-bit/radix-16 instances).
module tb_execute_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  op = 3'd0;
  logic [63:0] rs1 = 64'd0, rs2 = 64'd0;
  logic [4:0]  rd = 5'd0;
  logic        flush = 1'b0, res_ready = 1'b0;
  logic        rv32 = 1'b0, rv64 = 1'b0;

  logic        rr32, v32, busy32;
  logic [31:0] res32;
  logic [4:0]  rdo32;
  logic        rr64, v64, busy64;
  logic [63:0] res64;
  logic [4:0]  rdo64;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  execute_mdu #(.XLEN(32), .BITS_PER_CYCLE(1)) u_dut32 (
    .clk(clk), .rst(rst), .req_valid_i(rv32), .req_ready_o(rr32), .op_i(op),
    .rs1_i(rs1[31:0]), .rs2_i(rs2[31:0]), .rd_addr_i(rd), .flush_i(flush),
    .res_valid_o(v32), .res_ready_i(res_ready), .result_o(res32), .rd_addr_o(rdo32),
    .busy_o(busy32)
  );

  execute_mdu #(.XLEN(64), .BITS_PER_CYCLE(4)) u_dut64 (
    .clk(clk), .rst(rst), .req_valid_i(rv64), .req_ready_o(rr64), .op_i(op),
    .rs1_i(rs1), .rs2_i(rs2), .rd_addr_i(rd), .flush_i(flush),
    .res_valid_o(v64), .res_ready_i(res_ready), .result_o(res64), .rd_addr_o(rdo64),
    .busy_o(busy64)
  );

  function automatic logic obs_valid(input bit w);
    return w ? v64 : v32;
  endfunction
  function automatic logic obs_ready(input bit w);
    return w ? rr64 : rr32;
  endfunction
  function automatic logic obs_busy(input bit w);
    return w ? busy64 : busy32;
  endfunction
  function automatic logic [63:0] obs_res(input bit w);
    return w ? res64 : {32'd0, res32};
  endfunction
  function automatic logic [4:0] obs_rd(input bit w);
    return w ? rdo64 : rdo32;
  endfunction

  // Reference model built on native wide signed arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [63:0] a,
                                            input logic [63:0] b, input bit w);
    logic signed [129:0] sa, sb, ua, ub, p;
    logic [63:0] m;
    int sh;
    m  = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    sh = w ? 64 : 32;
    ua = {66'd0, a & m};
    ub = {66'd0, b & m};
    sa = w ? {{66{a[63]}}, a} : {{98{a[31]}}, a[31:0]};
    sb = w ? {{66{b[63]}}, b} : {{98{b[31]}}, b[31:0]};
    p  = ua;
    case (o)
      3'd0: p = ua * ub;
      3'd1: p = (sa * sb) >>> sh;
      3'd2: p = (sa * ub) >>> sh;
      3'd3: p = (ua * ub) >>> sh;
      3'd4: if (ub == 130'sd0) p = {130{1'b1}}; else p = sa / sb;
      3'd5: if (ub == 130'sd0) p = {130{1'b1}}; else p = ua / ub;
      3'd6: if (ub == 130'sd0) p = ua; else p = sa % sb;
      default: if (ub == 130'sd0) p = ua; else p = ua % ub;
    endcase
    return p[63:0] & m;
  endfunction

  function automatic int exp_lat(input bit w, input logic [2:0] o, input logic [63:0] a,
                                 input logic [63:0] b);
    logic [63:0] m, mn;
    int n;
    n  = w ? 17 : 33;
    m  = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    mn = w ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    if (o[2]) begin
      if ((b & m) == 64'd0) return 1;
      if (!o[0] && (a & m) == mn && (b & m) == m) return 1;
      return n;
    end
`ifdef MDU_FAST_MUL_EN
    return 1;
`else
    return n;
`endif
  endfunction

  // One full transaction: push expectation at issue, pop and compare at result.
  task automatic do_op(input bit w, input logic [2:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] d, input int stall);
    exp_t e, got;
    int cyc;
    e.res = ref_model(o, a, b, w);
    e.rd  = d;
    e.lat = exp_lat(w, o, a, b);
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; rd = d; res_ready = 1'b0;
    if (w) rv64 = 1'b1; else rv32 = 1'b1;
    #1;
    n_checks++;
    if (obs_ready(w) !== 1'b1) begin
      n_fail++; $display("FAIL req_ready_idle w=%0d: got %b want 1", w, obs_ready(w));
    end
    sb_q.push_back(e);
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk); rv32 = 1'b0; rv64 = 1'b0; cyc++;
    end while (obs_valid(w) !== 1'b1 && cyc < 200);
    got = sb_q.pop_front();
    n_checks++;
    if (cyc !== got.lat || obs_valid(w) !== 1'b1) begin
      n_fail++; $display("FAIL latency op=%0d w=%0d: got %0d want %0d", o, w, cyc, got.lat);
    end
    n_checks++;
    if (obs_res(w) !== got.res) begin
      n_fail++; $display("FAIL result op=%0d a=%h b=%h: got %h want %h", o, a, b, obs_res(w), got.res);
    end
    n_checks++;
    if (obs_rd(w) !== got.rd) begin
      n_fail++; $display("FAIL rd_addr: got %0d want %0d", obs_rd(w), got.rd);
    end
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs_valid(w) !== 1'b1 || obs_res(w) !== got.res) begin
        n_fail++; $display("FAIL hold cycle %0d: valid %b result %h want 1 %h", k, obs_valid(w), obs_res(w), got.res);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    n_checks++;
    if (obs_valid(w) !== 1'b0 || obs_busy(w) !== 1'b0 || obs_ready(w) !== 1'b1) begin
      n_fail++; $display("FAIL back_to_idle: valid %b busy %b ready %b want 0 0 1", obs_valid(w), obs_busy(w), obs_ready(w));
    end
  endtask

  task automatic test_reset;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (v32 !== 1'b0 || res32 !== 32'd0 || rdo32 !== 5'd0 || busy32 !== 1'b0 ||
        v64 !== 1'b0 || res64 !== 64'd0 || busy64 !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: v %b res %h rd %0d busy %b want 0 0 0 0", v32, res32, rdo32, busy32);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (rr32 !== 1'b1 || rr64 !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b %b want 1 1", rr32, rr64);
    end
  endtask

  task automatic test_mul;
    do_op(1'b0, 3'd0, 64'h7, 64'hFFFF_FFFD, 5'd5, 0);
    do_op(1'b0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd1, 0);
    do_op(1'b0, 3'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd2, 0);
    do_op(1'b0, 3'd2, 64'hFFFF_FFFF, 64'h2, 5'd3, 0);
    do_op(1'b0, 3'd1, 64'h8000_0000, 64'h7FFF_FFFF, 5'd4, 2);
  endtask

  task automatic test_div;
    do_op(1'b0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 5'd6, 0);
    do_op(1'b0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 5'd7, 0);
    do_op(1'b0, 3'd5, 64'd100, 64'd0, 5'd8, 0);
    do_op(1'b0, 3'd7, 64'd100, 64'd0, 5'd9, 0);
    do_op(1'b0, 3'd6, 64'hFFFF_FFF9, 64'd2, 5'd10, 0);
    do_op(1'b0, 3'd4, 64'hFFFF_FFF9, 64'd2, 5'd11, 0);
    do_op(1'b0, 3'd5, 64'd1000, 64'd7, 5'd12, 5);
    do_op(1'b0, 3'd7, 64'd1000, 64'd7, 5'd13, 0);
  endtask

  task automatic test_flush;
    bit saw_valid;
    saw_valid = 1'b0;
    @(negedge clk);
    op = 3'd4; rs1 = 64'd1000; rs2 = 64'd7; rd = 5'd14; rv32 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); rv32 = 1'b0;
      if (v32 === 1'b1) saw_valid = 1'b1;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++;
    if (busy32 !== 1'b0 || rr32 !== 1'b1) begin
      n_fail++; $display("FAIL flush_to_idle: busy %b ready %b want 0 1", busy32, rr32);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (v32 === 1'b1) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_result: saw valid %b want 0", saw_valid);
    end
    @(negedge clk);
    op = 3'd0; rs1 = 64'd3; rs2 = 64'd4; rv32 = 1'b1; flush = 1'b1;
    #1;
    n_checks++;
    if (rr32 !== 1'b0) begin
      n_fail++; $display("FAIL flush_gates_ready: got %b want 0", rr32);
    end
    @(negedge clk);
    rv32 = 1'b0; flush = 1'b0;
    #1;
    n_checks++;
    if (busy32 !== 1'b0) begin
      n_fail++; $display("FAIL flush_blocks_accept: busy %b want 0", busy32);
    end
    do_op(1'b0, 3'd0, 64'd3, 64'd4, 5'd15, 0);
  endtask

  task automatic test_flush_done;
    int cyc;
    @(negedge clk);
    op = 3'd3; rs1 = 64'd3; rs2 = 64'd4; rd = 5'd16; rv32 = 1'b1;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk); rv32 = 1'b0; cyc++;
    end while (v32 !== 1'b1 && cyc < 200);
    n_checks++;
    if (v32 !== 1'b1) begin
      n_fail++; $display("FAIL flush_done_reach: valid %b want 1", v32);
    end
    flush = 1'b1; res_ready = 1'b1;
    #1;
    n_checks++;
    if (v32 !== 1'b0) begin
      n_fail++; $display("FAIL flush_masks_valid: got %b want 0", v32);
    end
    @(negedge clk);
    flush = 1'b0; res_ready = 1'b0;
    #1;
    n_checks++;
    if (busy32 !== 1'b0 || v32 !== 1'b0) begin
      n_fail++; $display("FAIL flush_done_idle: busy %b valid %b want 0 0", busy32, v32);
    end
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    op = 3'd5; rs1 = 64'd5000; rs2 = 64'd3; rd = 5'd17; rv32 = 1'b1;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk); rv32 = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy32 !== 1'b0 || v32 !== 1'b0 || res32 !== 32'd0 || rdo32 !== 5'd0) begin
      n_fail++; $display("FAIL reset_mid_op: busy %b valid %b res %h rd %0d want 0 0 0 0", busy32, v32, res32, rdo32);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (rr32 !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", rr32);
    end
    do_op(1'b0, 3'd5, 64'd5000, 64'd3, 5'd18, 0);
  endtask

  task automatic test_wide;
    do_op(1'b1, 3'd4, 64'h7FFF_FFFF_FFFF_FFFF, 64'd3, 5'd19, 0);
    do_op(1'b1, 3'd0, 64'd3, 64'd4, 5'd20, 0);
    do_op(1'b1, 3'd1, 64'hF123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321, 5'd21, 1);
    do_op(1'b1, 3'd6, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd22, 0);
    do_op(1'b1, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd23, 0);
  endtask

  task automatic test_back_to_back;
    logic [63:0] a, b;
    logic [2:0]  o;
    bit          w;
    for (int k = 0; k < 16; k++) begin
      w = (k % 4) == 3;
      o = 3'($urandom_range(0, 7));
      a = {32'($urandom), 32'($urandom)};
      b = ($urandom_range(0, 5) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
      if (!w) begin
        a = a & 64'h0000_0000_FFFF_FFFF;
        b = b & 64'h0000_0000_FFFF_FFFF;
      end
      do_op(w, o, a, b, 5'(k), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_flush_done();
    test_reset_mid_op();
    test_wide();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_mdu.md
Name: execute_mdu

Overview:
- Parametrised multi-cycle RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) beside the execute-stage ALU.
- Execute dispatches operands with forwarding already resolved. The unit iterates, then returns the result on a valid/ready handshake toward MEM/WB.
- Generalised in data width and radix (bits per cycle). Adds a flush path and in-flight back-pressure, which the single-cycle ALU path does not have.

Parameters:
- XLEN, 32: operand/result width; legal values 32 or 64.
- BITS_PER_CYCLE, 1: multiplier/quotient bits retired per iteration; legal values 1, 2, 4; must divide XLEN.
- Illegal values are rejected by elaboration-time assertion.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- req_valid_i  input  1  operation request
- req_ready_o  output  1  unit can accept a request
- op_i  input  3  RV funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_i  input  XLEN  operand A (dividend / multiplicand)
- rs2_i  input  XLEN  operand B (divisor / multiplier)
- rd_addr_i  input  5  destination register
- flush_i  input  1  kill in-flight op (taken branch/jump/trap)
- res_valid_o  output  1  result available
- res_ready_i  input  1  consumer accepts result
- result_o  output  XLEN  result
- rd_addr_o  output  5  destination of result
- busy_o  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, counter 0, res_valid_o=0, result_o=0, rd_addr_o=0, busy_o=0, req_ready_o=1 once rst deasserts.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - req_ready_o=1.
  - Handshake (req_valid_i && req_ready_o) latches op_i, rs1_i, rs2_i, rd_addr_i.
  - Operands are converted to magnitudes plus sign flags per op signedness.
  - Next state: op<4 -> MUL, otherwise DIV. Special DIV cases go straight to DONE.
- MUL: shift-add, BITS_PER_CYCLE partial products per cycle, 2*XLEN accumulator. N = XLEN/BITS_PER_CYCLE iterations, then DONE.
- DIV: restoring division, BITS_PER_CYCLE quotient bits per cycle, N iterations, then DONE.
- Sign correction is applied on the last iteration cycle; DONE holds the final value.
- Latency: res_valid_o rises exactly N+1 cycles after the accepting edge (XLEN=32, BPC=1: 33 cycles).
- Result selection:
  - MUL -> low XLEN bits.
  - MULH/MULHSU/MULHU -> high XLEN bits.
  - DIV/DIVU -> quotient.
  - REM/REMU -> remainder; remainder sign follows the dividend.
- Special cases, detected at accept; res_valid_o rises on the next cycle:
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - Signed overflow (rs1 = most-negative value, rs2 = -1): DIV -> rs1; REM -> 0.
- DONE:
  - res_valid_o=1; result_o and rd_addr_o stable while res_ready_i=0.
  - res_ready_i=1 -> IDLE next cycle.
  - req_ready_o=0 in DONE, so no back-to-back accept in the same cycle.
- MUL/DIV/DONE: req_ready_o=0, busy_o=1.
- flush_i:
  - From any state -> IDLE next cycle. res_valid_o forced 0 that cycle; no result is emitted.
  - Flush in IDLE together with req_valid_i: flush wins, request is not accepted (req_ready_o gated by ~flush_i).
  - Flush in DONE together with res_ready_i: treated as flush; the result is considered not delivered.
- Reset mid-operation: immediate return to the reset values above; latched operands discarded.
- Counter width: $clog2(N)+1. It wraps only via reload on accept.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: MUL-class ops compute the full 2*XLEN product in one cycle. The FSM goes IDLE -> DONE, so res_valid_o rises 1 cycle after accept. The MUL state is unused. DIV is unchanged.
- Undefined: iterative multiply as above; no 2*XLEN multiplier is inferred.

Test Plan:
- XLEN=32, BPC=1, MUL rs1=7, rs2=0xFFFFFFFD -> result_o=0xFFFFFFEB, res_valid_o exactly 33 cycles after accept, rd_addr_o echoes rd_addr_i=5.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 1 cycle. REM same operands -> 0. DIVU 100/0 -> 0xFFFFFFFF. REMU 100/0 -> 100. REM -7 % 2 -> 0xFFFFFFFF.
- DIVU 1000/7 with res_ready_i low for 5 cycles after valid -> result_o=142 held stable; returns to IDLE the cycle after res_ready_i=1; REMU same operands -> 6.
- flush_i pulsed 10 cycles into a DIV -> busy_o=0 and req_ready_o=1 next cycle, res_valid_o never asserted. A new MUL 3x4 then returns 12.
- BPC=4, XLEN=64: DIV 0x7FFFFFFFFFFFFFFF / 3 -> 0x2AAAAAAAAAAAAAAA after 17 cycles. With MDU_FAST_MUL_EN, MUL 3x4 -> 12 after 1 cycle.
